// File: rtl/hub75_rx_capture.sv
// HUB75 receive-side capture: oversamples the panel pins, deserialises each shifted line,
// replays every latched line as a valid/ready pixel stream and measures OE on-time per row.
module hub75_rx_capture #(
    parameter  int hpixel_p      = 64,
    parameter  int vpixel_p      = 64,
    parameter  int segments_p    = 2,
    parameter  int sync_stages_p = 2,
    parameter  int ontime_wd_p   = 16,
    localparam int row_wd        = $clog2(vpixel_p / segments_p),
    localparam int col_wd        = $clog2(hpixel_p),
    localparam int rgb_wd        = 3 * segments_p
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic                   i_hub_clk,
    input  logic                   i_stb,
    input  logic                   i_oe,
    input  logic [row_wd-1:0]      i_row,
    input  logic [rgb_wd-1:0]      i_rgb,
    output logic                   o_pix_valid,
    input  logic                   i_pix_ready,
    output logic [col_wd-1:0]      o_pix_col,
    output logic [row_wd-1:0]      o_pix_row,
    output logic [rgb_wd-1:0]      o_pix_rgb,
    output logic                   o_line_done,
    output logic                   o_ontime_valid,
    output logic [ontime_wd_p-1:0] o_ontime,
    output logic [row_wd-1:0]      o_ontime_row,
    input  logic                   i_err_clr,
    output logic                   o_err_len,
    output logic                   o_err_oe,
    output logic                   o_err_ovf
);

    localparam int                cnt_wd     = $clog2(hpixel_p + 1);
    localparam logic [cnt_wd-1:0] line_len_c = cnt_wd'(hpixel_p);
    localparam logic [col_wd-1:0] last_col_c = col_wd'(hpixel_p - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    typedef struct packed {
        logic              hub_clk;
        logic              stb;
        logic              oe;
        logic [row_wd-1:0] row;
        logic [rgb_wd-1:0] rgb;
    } pins_t;

    pins_t pins_in;
    pins_t pins_a;
    pins_t sync_q [sync_stages_p+1];
    logic  hub_clk_p_q, stb_p_q, oe_p_q;
    logic  shift_ev, latch_ev, oe_rise, lit;

    state_t                  state_q, state_d;
    logic [cnt_wd-1:0]       shift_cnt_q, shift_cnt_d;
    logic [rgb_wd-1:0]       line_q [hpixel_p];
    logic [rgb_wd-1:0]       line_d [hpixel_p];
    logic [rgb_wd-1:0]       hold_q [hpixel_p];
    logic [rgb_wd-1:0]       hold_d [hpixel_p];
    logic                    pix_valid_q, pix_valid_d;
    logic [col_wd-1:0]       pix_col_q, pix_col_d;
    logic [row_wd-1:0]       pix_row_q, pix_row_d;
    logic [rgb_wd-1:0]       pix_rgb_q, pix_rgb_d;
    logic                    line_done_q, line_done_d;
    logic [ontime_wd_p-1:0]  ontime_cnt_q, ontime_cnt_d;
    logic                    ontime_valid_q, ontime_valid_d;
    logic [ontime_wd_p-1:0]  ontime_q, ontime_d;
    logic [row_wd-1:0]       ontime_row_q, ontime_row_d;
    logic                    err_len_q, err_len_d;
    logic                    err_oe_q, err_oe_d;
    logic                    err_ovf_q, err_ovf_d;

    assign pins_in = {i_hub_clk, i_stb, i_oe, i_row, i_rgb};

    // The last stage keeps data, row and OE aligned with the edge being detected on it.
    assign pins_a   = sync_q[sync_stages_p];
    assign shift_ev = i_enable & pins_a.hub_clk & ~hub_clk_p_q;
    assign latch_ev = i_enable & pins_a.stb & ~stb_p_q;
    assign oe_rise  = i_enable & pins_a.oe & ~oe_p_q;
    assign lit      = i_enable & ~pins_a.oe;

    // NOTE: sequential blocks use <= so every flop samples the pre-edge value of its source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= sync_stages_p; i++) sync_q[i] <= '0;
            hub_clk_p_q <= 1'b0;
            stb_p_q     <= 1'b0;
            oe_p_q      <= 1'b0;
        end else begin
            sync_q[0] <= pins_in;
            for (int i = 1; i <= sync_stages_p; i++) sync_q[i] <= sync_q[i-1];
            hub_clk_p_q <= pins_a.hub_clk;
            stb_p_q     <= pins_a.stb;
            oe_p_q      <= pins_a.oe;
        end
    end

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this block infers a latch.
        state_d        = state_q;
        shift_cnt_d    = shift_cnt_q;
        line_d         = line_q;
        hold_d         = hold_q;
        pix_valid_d    = pix_valid_q;
        pix_col_d      = pix_col_q;
        pix_row_d      = pix_row_q;
        pix_rgb_d      = pix_rgb_q;
        line_done_d    = 1'b0;
        ontime_cnt_d   = ontime_cnt_q;
        ontime_valid_d = 1'b0;
        ontime_d       = ontime_q;
        ontime_row_d   = ontime_row_q;
        err_len_d      = err_len_q & ~i_err_clr;
        err_oe_d       = err_oe_q & ~i_err_clr;
        err_ovf_d      = err_ovf_q & ~i_err_clr;

        if (shift_ev && shift_cnt_q != line_len_c) begin
            line_d[shift_cnt_q[col_wd-1:0]] = pins_a.rgb;
            shift_cnt_d                     = shift_cnt_q + cnt_wd'(1);
        end

        if (state_q == EMIT && i_pix_ready) begin
            if (pix_col_q == last_col_c) begin
                state_d     = IDLE;
                pix_valid_d = 1'b0;
                pix_col_d   = '0;
                pix_rgb_d   = '0;
                line_done_d = 1'b1;
            end else begin
                pix_col_d = pix_col_q + col_wd'(1);
                pix_rgb_d = hold_q[pix_col_q + col_wd'(1)];
            end
        end

        // Latch sees the post-shift buffer, so a same-cycle pixel belongs to the latched line.
        if (latch_ev) begin
            if (shift_cnt_d != line_len_c) err_len_d = 1'b1;
            if (!pins_a.oe)                err_oe_d  = 1'b1;
            if (state_q == IDLE) begin
                hold_d      = line_d;
                pix_row_d   = pins_a.row;
                state_d     = EMIT;
                pix_valid_d = 1'b1;
                pix_col_d   = '0;
                pix_rgb_d   = line_d[0];
            end else begin
                err_ovf_d = 1'b1;
            end
            shift_cnt_d = '0;
        end

        if (oe_rise) begin
            ontime_d       = ontime_cnt_q;
            ontime_row_d   = pins_a.row;
            ontime_valid_d = 1'b1;
            ontime_cnt_d   = '0;
        end else if (lit && ontime_cnt_q != '1) begin
            ontime_cnt_d = ontime_cnt_q + ontime_wd_p'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            shift_cnt_q    <= '0;
            // NOTE: both buffers are cleared on reset so no line captured before reset can ever replay.
            for (int i = 0; i < hpixel_p; i++) begin
                line_q[i] <= '0;
                hold_q[i] <= '0;
            end
            pix_valid_q    <= 1'b0;
            pix_col_q      <= '0;
            pix_row_q      <= '0;
            pix_rgb_q      <= '0;
            line_done_q    <= 1'b0;
            ontime_cnt_q   <= '0;
            ontime_valid_q <= 1'b0;
            ontime_q       <= '0;
            ontime_row_q   <= '0;
            err_len_q      <= 1'b0;
            err_oe_q       <= 1'b0;
            err_ovf_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_cnt_q    <= shift_cnt_d;
            line_q         <= line_d;
            hold_q         <= hold_d;
            pix_valid_q    <= pix_valid_d;
            pix_col_q      <= pix_col_d;
            pix_row_q      <= pix_row_d;
            pix_rgb_q      <= pix_rgb_d;
            line_done_q    <= line_done_d;
            ontime_cnt_q   <= ontime_cnt_d;
            ontime_valid_q <= ontime_valid_d;
            ontime_q       <= ontime_d;
            ontime_row_q   <= ontime_row_d;
            err_len_q      <= err_len_d;
            err_oe_q       <= err_oe_d;
            err_ovf_q      <= err_ovf_d;
        end
    end

    assign o_pix_valid    = pix_valid_q;
    assign o_pix_col      = pix_col_q;
    assign o_pix_row      = pix_row_q;
    assign o_pix_rgb      = pix_rgb_q;
    assign o_line_done    = line_done_q;
    assign o_ontime_valid = ontime_valid_q;
    assign o_ontime       = ontime_q;
    assign o_ontime_row   = ontime_row_q;
    assign o_err_len      = err_len_q;
    assign o_err_oe       = err_oe_q;
    assign o_err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_hub75_rx_capture.sv
// Self-checking bench for hub75_rx_capture: table-driven line vectors, hand-written corner
// sequences and randomized lines, all checked against a line-level behavioural model.
module tb_hub75_rx_capture;

    localparam int hpixel_p = 64, vpixel_p = 64, segments_p = 2, sync_stages_p = 2, ontime_wd_p = 16;
    localparam int row_wd = 5, col_wd = 6, rgb_wd = 6;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   i_enable, i_hub_clk, i_stb, i_oe, i_pix_ready, i_err_clr;
    logic [row_wd-1:0]      i_row;
    logic [rgb_wd-1:0]      i_rgb;
    logic                   o_pix_valid, o_line_done, o_ontime_valid, o_err_len, o_err_oe, o_err_ovf;
    logic [col_wd-1:0]      o_pix_col;
    logic [row_wd-1:0]      o_pix_row, o_ontime_row;
    logic [rgb_wd-1:0]      o_pix_rgb;
    logic [ontime_wd_p-1:0] o_ontime;

    always #5 clk = ~clk;

    hub75_rx_capture #(
        .hpixel_p(hpixel_p), .vpixel_p(vpixel_p), .segments_p(segments_p),
        .sync_stages_p(sync_stages_p), .ontime_wd_p(ontime_wd_p)
    ) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_hub_clk(i_hub_clk), .i_stb(i_stb),
        .i_oe(i_oe), .i_row(i_row), .i_rgb(i_rgb), .o_pix_valid(o_pix_valid),
        .i_pix_ready(i_pix_ready), .o_pix_col(o_pix_col), .o_pix_row(o_pix_row),
        .o_pix_rgb(o_pix_rgb), .o_line_done(o_line_done), .o_ontime_valid(o_ontime_valid),
        .o_ontime(o_ontime), .o_ontime_row(o_ontime_row), .i_err_clr(i_err_clr),
        .o_err_len(o_err_len), .o_err_oe(o_err_oe), .o_err_ovf(o_err_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a line is just an array filled in shift order; a latch snapshots it.
    logic [5:0] model_line [hpixel_p];
    logic [5:0] exp_line   [hpixel_p];
    int         model_cnt, exp_row;
    bit         model_busy, exp_len, exp_oe, exp_ovf;

    function automatic void model_reset();
        for (int k = 0; k < hpixel_p; k++) model_line[k] = '0;
        model_cnt = 0; model_busy = 0; exp_len = 0; exp_oe = 0; exp_ovf = 0;
    endfunction

    function automatic void model_latch(input int row, input logic oe);
        if (!i_enable) return;
        if (model_cnt != hpixel_p) exp_len = 1;
        if (!oe) exp_oe = 1;
        if (model_busy) exp_ovf = 1;
        else begin
            for (int k = 0; k < hpixel_p; k++) exp_line[k] = model_line[k];
            exp_row    = row;
            model_busy = 1;
        end
        model_cnt = 0;
    endfunction

    typedef struct { int col; int row; int rgb; } pix_t;
    typedef struct { int t; int row; } ot_t;
    pix_t got_q [$];
    ot_t  ot_q  [$];
    int   done_cnt = 0, done_ref = 0, ready_mode = 0;
    bit   hold_pending = 0;
    logic [col_wd-1:0] hold_col;
    logic [rgb_wd-1:0] hold_rgb;

    // Monitor on the falling edge: collects accepted pixels and checks stall stability.
    always @(negedge clk) begin
        if (rst) hold_pending = 0;
        else begin
            if (hold_pending) begin
                check("stall_valid", o_pix_valid, 1);
                check("stall_col", o_pix_col, hold_col);
                check("stall_rgb", o_pix_rgb, hold_rgb);
            end
            hold_pending = o_pix_valid && !i_pix_ready;
            hold_col     = o_pix_col;
            hold_rgb     = o_pix_rgb;
            if (o_pix_valid && i_pix_ready) got_q.push_back('{int'(o_pix_col), int'(o_pix_row), int'(o_pix_rgb)});
            if (o_line_done) done_cnt++;
            if (o_ontime_valid) ot_q.push_back('{int'(o_ontime), int'(o_ontime_row)});
        end
    end

    initial begin
        i_pix_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       i_pix_ready = 1'b1;
                1:       i_pix_ready = ~i_pix_ready;
                default: i_pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic hub_pulse(input logic [5:0] rgb);
        i_rgb = rgb; i_hub_clk = 1'b1; tick(2);
        i_hub_clk = 1'b0; tick(2);
        if (i_enable && model_cnt < hpixel_p) begin
            model_line[model_cnt] = rgb;
            model_cnt++;
        end
    endtask

    task automatic strobe(input int row, input logic oe);
        i_row = row_wd'(row); i_oe = oe; i_stb = 1'b1; tick(2);
        i_stb = 1'b0; tick(2);
        i_oe = 1'b1;
        model_latch(row, oe);
    endtask

    task automatic clear_errs();
        i_err_clr = 1'b1; tick(1);
        i_err_clr = 1'b0; tick(1);
        exp_len = 0; exp_oe = 0; exp_ovf = 0;
    endtask

    task automatic check_errs();
        check("err_len", o_err_len, exp_len);
        check("err_oe", o_err_oe, exp_oe);
        check("err_ovf", o_err_ovf, exp_ovf);
    endtask

    task automatic check_zero_outputs();
        check("rst_pix_valid", o_pix_valid, 0);
        check("rst_pix_col", o_pix_col, 0);
        check("rst_pix_row", o_pix_row, 0);
        check("rst_pix_rgb", o_pix_rgb, 0);
        check("rst_line_done", o_line_done, 0);
        check("rst_ontime_valid", o_ontime_valid, 0);
        check("rst_ontime", o_ontime, 0);
        check("rst_ontime_row", o_ontime_row, 0);
        check("rst_err_len", o_err_len, 0);
        check("rst_err_oe", o_err_oe, 0);
        check("rst_err_ovf", o_err_ovf, 0);
    endtask

    task automatic check_line();
        int waited = 0;
        while (done_cnt == done_ref && waited < 3000) begin tick(1); waited++; end
        tick(2);
        check("line_done_count", done_cnt - done_ref, 1);
        check("line_pixel_count", got_q.size(), hpixel_p);
        for (int k = 0; k < got_q.size() && k < hpixel_p; k++) begin
            check("pix_col", got_q[k].col, k);
            check("pix_rgb", got_q[k].rgb, exp_line[k]);
            check("pix_row", got_q[k].row, exp_row);
        end
        check("valid_after_done", o_pix_valid, 0);
        got_q.delete();
        done_ref   = done_cnt;
        model_busy = 0;
    endtask

    typedef struct {
        int   npulses;
        int   row;
        logic oe;
        int   ready;
        logic exp_len;
        logic exp_oe;
        logic exp_ovf;
    } vec_t;

    vec_t vecs [5];
    int   lat;

    initial begin
        vecs[0] = '{64,  7, 1'b1, 1, 1'b0, 1'b0, 1'b0};  // full line, toggling ready
        vecs[1] = '{63,  2, 1'b1, 0, 1'b1, 1'b0, 1'b0};  // short line, col 63 stale
        vecs[2] = '{65,  9, 1'b1, 2, 1'b0, 1'b0, 1'b0};  // extra pulse discarded at saturation
        vecs[3] = '{64, 31, 1'b0, 2, 1'b0, 1'b1, 1'b0};  // latch while lit
        vecs[4] = '{ 0,  0, 1'b1, 0, 1'b1, 1'b0, 1'b0};  // no pulses, whole line stale

        rst = 1'b1; i_enable = 1'b1; i_hub_clk = 1'b0; i_stb = 1'b0; i_oe = 1'b1;
        i_row = '0; i_rgb = '0; i_err_clr = 1'b0;
        model_reset();
        tick(3);
        check_zero_outputs();
        rst = 1'b0;
        tick(10);
        ot_q.delete();
        done_ref = done_cnt;

        // Nominal line with latch latency measurement.
        ready_mode = 0;
        for (int k = 0; k < hpixel_p; k++) hub_pulse(6'(k));
        i_row = 5; i_oe = 1'b1; i_stb = 1'b1;
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            tick(1);
            if (o_pix_valid && lat == 0) lat = c;
        end
        i_stb = 1'b0; tick(2);
        model_latch(5, 1'b1);
        check("latch_latency", lat, sync_stages_p + 2);
        check_errs();
        check_line();

        for (int v = 0; v < 5; v++) begin
            clear_errs();
            check("err_len_cleared", o_err_len, 0);
            ready_mode = vecs[v].ready;
            for (int k = 0; k < vecs[v].npulses; k++) hub_pulse(6'($urandom));
            strobe(vecs[v].row, vecs[v].oe);
            tick(3);
            check("vec_err_len", o_err_len, vecs[v].exp_len);
            check("vec_err_oe", o_err_oe, vecs[v].exp_oe);
            check("vec_err_ovf", o_err_ovf, vecs[v].exp_ovf);
            check_line();
        end

        // Overrun: second STB during a slow replay must not disturb the first line.
        clear_errs();
        ready_mode = 1;
        for (int k = 0; k < hpixel_p; k++) hub_pulse(6'($urandom));
        strobe(4, 1'b1);
        check("ovf_replay_running", o_pix_valid, 1);
        strobe(6, 1'b1);
        tick(3);
        check_errs();
        check_line();
        tick(20);
        check("ovf_no_extra_pixels", got_q.size(), 0);
        check("ovf_no_extra_done", done_cnt - done_ref, 0);

        // On-time: 128 lit cycles on row 3.
        ready_mode = 0;
        tick(10);
        ot_q.delete();
        i_row = 3; i_oe = 1'b0;
        tick(128);
        i_oe = 1'b1;
        tick(8);
        check("ontime_pulses", ot_q.size(), 1);
        if (ot_q.size() > 0) begin
            check("ontime_value", ot_q[0].t, 128);
            check("ontime_row", ot_q[0].row, 3);
        end
        ot_q.delete();

        // Disabled capture: pulses, strobe and OE activity are all ignored.
        clear_errs();
        i_enable = 1'b0;
        for (int k = 0; k < hpixel_p; k++) hub_pulse(6'($urandom));
        strobe(12, 1'b0);
        tick(10);
        check("dis_no_pixels", got_q.size(), 0);
        check("dis_no_done", done_cnt - done_ref, 0);
        check("dis_no_ontime", ot_q.size(), 0);
        check("dis_valid", o_pix_valid, 0);
        check_errs();
        i_enable = 1'b1;
        tick(4);
        for (int k = 0; k < hpixel_p; k++) hub_pulse(6'($urandom));
        strobe(12, 1'b1);
        tick(3);
        check_errs();
        check_line();

        // Randomized lines against the model, sticky errors accumulate.
        clear_errs();
        ready_mode = 2;
        for (int it = 0; it < 6; it++) begin
            int n   = $urandom_range(62, 66);
            int row = $urandom_range(0, 31);
            for (int k = 0; k < n; k++) hub_pulse(6'($urandom));
            strobe(row, 1'b1);
            tick(3);
            check_errs();
            check_line();
        end

        // Reset in the middle of a replay.
        ready_mode = 0;
        for (int k = 0; k < hpixel_p; k++) hub_pulse(6'($urandom));
        strobe(9, 1'b1);
        lat = 0;
        while (!(o_pix_valid && o_pix_col == 20) && lat < 500) begin tick(1); lat++; end
        check("mid_reset_reached_col20", o_pix_col, 20);
        rst = 1'b1;
        #1;
        check_zero_outputs();
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(10);
        got_q.delete();
        ot_q.delete();
        done_ref = done_cnt;
        for (int k = 0; k < hpixel_p; k++) hub_pulse(6'($urandom));
        strobe(17, 1'b1);
        tick(3);
        check_errs();
        check_line();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
